// File: rtl/apb_slave_mem_pkg.sv
// Shared types and constants for the APB completer memory.
package apb_slave_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int WAIT_MAX       = 7;
    localparam int WAIT_CNT_W     = 3;

endpackage

// File: rtl/apb_slave_mem_array.sv
// Word-organised storage: synchronous write, combinational read index, async clear.
module apb_slave_mem_array #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // NOTE: every word is cleared on reset, so this array maps to flops rather
    // than a RAM macro; a RAM could not honour the asynchronous clear.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer memory with programmable wait states.
// Optional error response enabled by defining APB_SLAVE_MEM_PSLVERR_EN.
module apb_slave_mem
    import apb_slave_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int WAIT_STATES = 1
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [31:0]           paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata
`ifdef APB_SLAVE_MEM_PSLVERR_EN
    ,
    output logic                  pslverr
`endif
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic                    write_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   prdata_q;

    logic [ADDR_WIDTH-1:0]   addr_idx;
    logic                    addr_err;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    assign addr_idx = paddr[ADDR_WIDTH+1:2];

`ifdef APB_SLAVE_MEM_PSLVERR_EN
    assign addr_err = (paddr[31:ADDR_WIDTH+2] != '0) || (paddr[1:0] != 2'b00);
    assign pslverr  = pready && err_q;
`else
    // Upper and byte-lane address bits are deliberately ignored: addresses alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{paddr[31:ADDR_WIDTH+2], paddr[1:0]};
    assign addr_err         = 1'b0;
`endif

    // NOTE: next-state is defaulted to the current state before the case so that
    // no path through this block leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (psel && !penable) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = (psel && !penable) ? SETUP : IDLE;
                end else if (!(psel && penable)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pready = (state_q == ACCESS) && (cnt_q == '0);
    assign mem_we = pready && write_q && !err_q;
    assign prdata = prdata_q;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == SETUP) begin
                idx_q   <= addr_idx;
                write_q <= pwrite;
                err_q   <= addr_err;
                cnt_q   <= WAIT_LOAD;
                if (!pwrite) prdata_q <= addr_err ? '0 : mem_rdata;
            end else if ((state_q == ACCESS) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - WAIT_CNT_W'(1);
            end
        end
    end

    apb_slave_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .pclk    (pclk),
        .presetn (presetn),
        .we      (mem_we),
        .waddr   (idx_q),
        .wdata   (pwdata),
        .raddr   (addr_idx),
        .rdata   (mem_rdata)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench: three completers (WAIT_STATES 1, 0, 3) on a shared bus,
// compared against a word-array reference model.
`timescale 1ns/1ps
module tb_apb_slave_mem;

    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int NDUT  = 3;
    localparam int NRAND = 40;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        bit          chain;
    } op_t;

    logic          pclk;
    logic          presetn;
    logic [2:0]    psel_v;
    logic          penable;
    logic          pwrite;
    logic [31:0]   paddr;
    logic [DW-1:0] pwdata;
    logic [2:0]    pready_v;
    logic [2:0]    pslverr_v;
    logic [DW-1:0] prdata_v [NDUT];

    int            checks;
    int            failures;
    int            cur;
    bit            pre_setup;
    logic [31:0]   mem_m   [NDUT][DEPTH];
    logic [31:0]   last_rd [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        apb_slave_mem #(
            .ADDR_WIDTH  (AW),
            .DATA_WIDTH  (DW),
            .WAIT_STATES (g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .pclk    (pclk),
            .presetn (presetn),
            .psel    (psel_v[g]),
            .penable (penable),
            .pwrite  (pwrite),
            .paddr   (paddr),
            .pwdata  (pwdata),
            .pready  (pready_v[g]),
            .prdata  (prdata_v[g])
`ifdef APB_SLAVE_MEM_PSLVERR_EN
            ,
            .pslverr (pslverr_v[g])
`endif
        );
    end

`ifndef APB_SLAVE_MEM_PSLVERR_EN
    assign pslverr_v = 3'b000;
`endif

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic logic addr_err(input logic [31:0] a);
`ifdef APB_SLAVE_MEM_PSLVERR_EN
        return (a[31:AW+2] != '0) || (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 15)) << 2;
        case ($urandom_range(0, 7))
            0:       a = a | 32'($urandom_range(1, 3));
            1:       a = a | (32'($urandom_range(1, 255)) << 8);
            default: ;
        endcase
        return a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            last_rd[k] = '0;
            for (int i = 0; i < DEPTH; i++) mem_m[k][i] = '0;
        end
    endtask

    // Drives one transfer on DUT 'cur'; when chain is set, the completing cycle
    // already presents the next setup phase (nw/na).
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit chain, input logic nw, input logic [31:0] na,
                        output logic [31:0] rd, output logic er, output int lat);
        bit done;
        done = 1'b0;
        rd   = '0;
        er   = 1'b0;
        if (!pre_setup) begin
            psel_v      = 3'b000;
            psel_v[cur] = 1'b1;
            penable     = 1'b0;
            pwrite      = w;
            paddr       = a;
            pwdata      = d;
            @(negedge pclk);
        end
        lat       = 1;
        pre_setup = 1'b0;
        pwrite    = w;
        paddr     = a;
        penable   = 1'b1;
        pwdata    = d;
        while (!done && lat < 20) begin
            @(negedge pclk);
            lat++;
            if (pready_v[cur]) begin
                done = 1'b1;
                rd   = prdata_v[cur];
                er   = pslverr_v[cur];
                if (chain) begin
                    penable   = 1'b0;
                    pwrite    = nw;
                    paddr     = na;
                    pre_setup = 1'b1;
                end else begin
                    psel_v  = 3'b000;
                    penable = 1'b0;
                end
                @(negedge pclk);
            end
        end
        check("pready_timeout", 32'(done), 32'd1);
        if (!done) begin
            psel_v  = 3'b000;
            penable = 1'b0;
        end
    endtask

    task automatic do_xfer(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input bit chain,
                           input logic nw, input logic [31:0] na);
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          idx;
        logic        exp_er;
        xfer(w, a, d, chain, nw, na, rd, er, lat);
        exp_er = addr_err(a);
        idx    = int'((a >> 2) % DEPTH);
        if (w) begin
            if (!exp_er) mem_m[cur][idx] = d;
        end else begin
            last_rd[cur] = exp_er ? 32'h0 : mem_m[cur][idx];
        end
        check({tag, "_latency"}, 32'(lat), 32'(2 + ws_of(cur)));
        check({tag, "_prdata"}, rd, last_rd[cur]);
        check({tag, "_pslverr"}, 32'(er), 32'(exp_er));
    endtask

    initial begin
        op_t ops[$];
        checks    = 0;
        failures  = 0;
        cur       = 0;
        pre_setup = 1'b0;
        presetn   = 1'b0;
        psel_v    = 3'b000;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = '0;
        pwdata    = '0;
        model_reset();

        repeat (3) @(negedge pclk);
        for (int k = 0; k < NDUT; k++) begin
            check("reset_pready", 32'(pready_v[k]), 32'd0);
            check("reset_prdata", prdata_v[k], 32'h0);
            check("reset_pslverr", 32'(pslverr_v[k]), 32'd0);
        end
        presetn = 1'b1;
        @(negedge pclk);

        do_xfer("rd_after_reset", 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);

        do_xfer("wr_b2b", 1'b1, 32'h04, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h04);
        do_xfer("rd_b2b", 1'b0, 32'h04, 32'h0, 1'b0, 1'b0, 32'h0);
        check("rd_b2b_value", last_rd[0], 32'hDEAD_BEEF);

        for (int k = 1; k < NDUT; k++) begin
            cur = k;
            do_xfer("ws_wr", 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
            do_xfer("ws_rd", 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0);
        end
        cur = 0;

        // Protocol error from IDLE: psel and penable together must be ignored.
        psel_v[0] = 1'b1;
        penable   = 1'b1;
        pwrite    = 1'b1;
        paddr     = 32'h04;
        pwdata    = 32'h0BAD_0BAD;
        repeat (3) begin
            @(negedge pclk);
            check("proto_err_pready", 32'(pready_v[0]), 32'd0);
        end
        psel_v  = 3'b000;
        penable = 1'b0;
        @(negedge pclk);
        do_xfer("proto_err_rd", 1'b0, 32'h04, 32'h0, 1'b0, 1'b0, 32'h0);

        // Write aborted by dropping psel during the wait state.
        do_xfer("abort_pre_wr", 1'b1, 32'h08, 32'hAAAA_5555, 1'b0, 1'b0, 32'h0);
        psel_v[0] = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b1;
        paddr     = 32'h08;
        pwdata    = 32'h1111_2222;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        check("abort_wait_pready", 32'(pready_v[0]), 32'd0);
        psel_v  = 3'b000;
        penable = 1'b0;
        @(negedge pclk);
        check("abort_idle_pready", 32'(pready_v[0]), 32'd0);
        check("abort_prdata_held", prdata_v[0], last_rd[0]);
        do_xfer("abort_rd", 1'b0, 32'h08, 32'h0, 1'b0, 1'b0, 32'h0);
        check("abort_rd_value", last_rd[0], 32'hAAAA_5555);

        // Reset pulse in the middle of a write's wait state.
        do_xfer("rst_pre_wr", 1'b1, 32'h0C, 32'h0C0C_0C0C, 1'b0, 1'b0, 32'h0);
        do_xfer("rst_pre_rd", 1'b0, 32'h0C, 32'h0, 1'b0, 1'b0, 32'h0);
        psel_v[0] = 1'b1;
        penable   = 1'b0;
        pwrite    = 1'b1;
        paddr     = 32'h0C;
        pwdata    = 32'h5555_AAAA;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check("rst_mid_pready", 32'(pready_v[k]), 32'd0);
            check("rst_mid_prdata", prdata_v[k], 32'h0);
        end
        psel_v  = 3'b000;
        penable = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        model_reset();
        @(negedge pclk);
        do_xfer("rst_rd", 1'b0, 32'h0C, 32'h0, 1'b0, 1'b0, 32'h0);

        // Out-of-range and misaligned accesses: error with the option, alias without.
        do_xfer("err_wr0", 1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 1'b0, 1'b0, 32'h0);
        do_xfer("err_wr_oor", 1'b1, 32'h0000_1000, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        do_xfer("err_rd0", 1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 32'h0);
        do_xfer("err_wr_mis", 1'b1, 32'h0000_0006, 32'h6666_6666, 1'b0, 1'b0, 32'h0);
        do_xfer("err_rd4", 1'b0, 32'h0000_0004, 32'h0, 1'b0, 1'b0, 32'h0);
        do_xfer("err_rd_oor", 1'b0, 32'h0000_1004, 32'h0, 1'b0, 1'b0, 32'h0);

        for (int k = 0; k < NDUT; k++) begin
            cur = k;
            ops.delete();
            for (int i = 0; i <= NRAND; i++) begin
                op_t op;
                op.w     = 1'($urandom_range(0, 1));
                op.a     = rand_addr();
                op.d     = $urandom;
                op.chain = ($urandom_range(0, 1) == 1);
                ops.push_back(op);
            end
            for (int i = 0; i < NRAND; i++) begin
                do_xfer("rand", ops[i].w, ops[i].a, ops[i].d,
                        ops[i].chain && (i < NRAND - 1), ops[i+1].w, ops[i+1].a);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
